opram_loader: RTL and testbench
===============================

# opram_loader

Host-side program loader sitting directly upstream of the 256×8 op RAM controller. It receives a framed byte stream from the host link over a valid/ready handshake and writes the payload into consecutive op RAM addresses. It checks an 8-bit checksum and raises `busy` so the core stalls while a load is in progress. When idle, it passes the core's fetch address straight through to the op RAM address input.

## Interface
Parameters:
- `TIMEOUT`, 65535: idle cycles allowed between bytes inside a frame before the frame is aborted.
- `SYNC`, 8'hA5: frame start byte.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  8  byte from the host link.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `fetch_addr`  in  8  core program counter.
- `addr`  out  8  to op RAM `addr`.
- `writeop`  out  8  to op RAM `writeop`.
- `write`  out  1  to op RAM `write`.
- `busy`  out  1  frame in progress; core must stall.
- `done`  out  1  one-cycle pulse when a frame completes with a good checksum.
- `err`  out  1  sticky error flag; cleared when the next SYNC is accepted.

## Operation
- A byte is accepted on any edge where `in_valid && in_ready`.
- Frame format: SYNC, start address A, length L (L=0 means 256), L data bytes, checksum C.
- C must equal the 8-bit modular sum of the data bytes.
- States: IDLE, ADDR, LEN, DATA, CHK, DONE.
  - IDLE: a SYNC byte moves to ADDR and clears `err`. Any other byte is consumed and dropped; remain in IDLE.
  - ADDR: latch A into the write pointer; go to LEN.
  - LEN: latch L into a 9-bit remaining count (0 maps to 256); clear the checksum accumulator; go to DATA.
  - DATA: each accepted byte is written at the pointer and added to the sum. Pointer increments mod 256, so 8'hFF wraps to 8'h00. Count decrements; when it reaches 0, go to CHK.
  - CHK: the byte is compared with the sum. Match: `done` pulses; mismatch: `err`=1. Go to DONE either way.
  - DONE: one cycle, then IDLE.
- Timeout: a 16-bit counter clears on every accepted byte and increments each cycle in ADDR, LEN, DATA and CHK.
  - When it reaches TIMEOUT, set `err`=1 and go to IDLE.
  - Bytes already written are not rolled back.
- `in_ready` = 1 in IDLE, ADDR, LEN, DATA, CHK; 0 in DONE.
- `busy` = 1 in every state except IDLE.
- `addr` = `fetch_addr` when `busy`=0, otherwise the registered write address. `fetch_addr` is ignored while busy.

## Timing
- Reset values: state IDLE, `write` 0, `writeop` 0, write address 0, `busy` 0, `done` 0, `err` 0, timeout counter 0. `in_ready` is 1 and `addr` equals `fetch_addr` from the first cycle after reset.
- Write latency: a data byte accepted at edge t produces `write`=1 with `writeop`=byte and the registered address during cycle t..t+1. The op RAM captures it at edge t+1.
- `write` is high for exactly one cycle per data byte. Back-to-back bytes give back-to-back writes.
- `busy` rises in the cycle after SYNC is accepted. It falls in the cycle after DONE, which is at least one cycle after the last write, so the final write completes under `busy`.
- `done` is asserted during the DONE cycle only.
- Reset mid-frame returns to IDLE on that edge. `write` is 0 in the following cycle and `err` is 0; partial RAM contents are retained.
- A timeout and a byte arriving on the same edge: the byte wins and the counter clears.

## Structure
- Package `opram_loader_pkg` holds the state enum, the default SYNC value and the 256-byte length-zero constant.
- Single module, no sub-module. The checksum, count and timeout logic are small enough to stay inline.
- Instantiated beside `opram_control`, driving its `write`, `writeop` and `addr`.

## Test plan
- Frame A5,10,03,01,02,03,06 → writes 01@10, 02@11, 03@12 on consecutive cycles; `done` pulses; `err`=0; `busy` high from the cycle after A5 through DONE.
- Frame A5,FE,03,11,22,33,66 → writes at FE, FF, 00 (wrap); `done` pulses.
- Frame A5,00,00, 256 bytes 00..FF, then 80 → 256 writes; sum is 8'h80 → `done` pulses.
- Frame A5,20,02,05,05 followed by C=00 → both writes occur, `err`=1, no `done`. A following A5 clears `err`.
- Frame A5,40,04,AA then `in_valid` low for TIMEOUT cycles (TIMEOUT=16 in the bench) → `err`=1, state IDLE, `busy`=0. Also check stray bytes 00, 5A in IDLE are dropped with no write, and that `addr` tracks `fetch_addr` while idle.
- Assert `rst` during DATA of A5,30,04 after 2 bytes → the next cycle has `write`=0, `busy`=0, `err`=0; addresses 30 and 31 were written.

Source files
------------

// File: rtl/opram_loader_pkg.sv
// Shared types and constants for the op RAM program loader.
package opram_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE
  } state_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [8:0] LEN_ZERO     = 9'd256;

endpackage

// File: rtl/opram_loader.sv
// Framed host byte stream -> op RAM writes with checksum; each data byte is written in the cycle after it is accepted.
// in_ready drops only in the DONE cycle; busy stalls the core for the whole frame.
module opram_loader
  import opram_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535,
  parameter logic [7:0]  SYNC    = SYNC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] fetch_addr,
  output logic [7:0] addr,
  output logic [7:0] writeop,
  output logic       write,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        accept;
  logic        tmo_active;
  logic        tmo_hit;
  logic [7:0]  wr_ptr;
  logic [8:0]  remaining;
  logic [7:0]  sum;
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = (state != S_DONE);
    busy       = (state != S_IDLE);
    accept     = in_valid && in_ready;
    tmo_active = (state == S_ADDR) || (state == S_LEN) ||
                 (state == S_DATA) || (state == S_CHK);
    tmo_hit    = 1'b0;
    case (state)
      S_IDLE:  if (accept && in_data == SYNC) state_nxt = S_ADDR;
      S_ADDR:  if (accept) state_nxt = S_LEN;
      S_LEN:   if (accept) state_nxt = S_DATA;
      S_DATA:  if (accept && remaining == 9'd1) state_nxt = S_CHK;
      S_CHK:   if (accept) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // An arriving byte always beats an expiring timeout.
    if (tmo_active && !accept && tmo_cnt == TMO_LAST) begin
      tmo_hit   = 1'b1;
      state_nxt = S_IDLE;
    end
  end

  assign addr = busy ? wr_ptr : fetch_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= 8'h00;
      remaining <= 9'd0;
      sum       <= 8'h00;
      tmo_cnt   <= 16'h0000;
      write     <= 1'b0;
      writeop   <= 8'h00;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      write <= 1'b0;
      done  <= 1'b0;
      // The pointer steps after each write completes, so addr stays stable while write is high.
      if (write) wr_ptr <= wr_ptr + 8'h01;

      if (!tmo_active || accept || tmo_hit) tmo_cnt <= 16'h0000;
      else                                  tmo_cnt <= tmo_cnt + 16'h0001;
      if (tmo_hit) err <= 1'b1;

      if (accept) begin
        case (state)
          S_IDLE: if (in_data == SYNC) err <= 1'b0;
          S_ADDR: wr_ptr <= in_data;
          S_LEN: begin
            remaining <= (in_data == 8'h00) ? LEN_ZERO : {1'b0, in_data};
            sum       <= 8'h00;
          end
          S_DATA: begin
            write     <= 1'b1;
            writeop   <= in_data;
            sum       <= sum + in_data;
            remaining <= remaining - 9'd1;
          end
          S_CHK: begin
            if (in_data == sum) done <= 1'b1;
            else                err  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_opram_loader.sv
// Bench for opram_loader: frame table plus hand sequences, op RAM writes checked against a scoreboard.
module tb_opram_loader;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] fetch_addr;
  logic [7:0] addr;
  logic [7:0] writeop;
  logic       write;
  logic       busy;
  logic       done;
  logic       err;

  opram_loader #(.TIMEOUT(TMO), .SYNC(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fetch_addr (fetch_addr),
    .addr       (addr),
    .writeop    (writeop),
    .write      (write),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] len;
    logic [7:0] first;
    logic [7:0] step;
    logic [7:0] chk;
    logic       exp_done;
    logic       exp_err;
  } frame_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write seen on the RAM port must match the next expected one.
  always @(negedge clk) begin
    if (write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got %0h@%0h, want no write", writeop, addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", {8'h00, addr}, {8'h00, e.a});
        check("write_data", {8'h00, writeop}, {8'h00, e.d});
        check("write_busy", {15'h0, busy}, 16'h1);
      end
    end
  end

  // Drives one byte and returns 1 ns after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    bit rdy;
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      tries++;
      if (tries > 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_byte: in_ready stayed 0, want 1 within 20 cycles");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f);
    int         n;
    logic [7:0] d;
    send_byte(8'hA5);
    check("busy_after_sync", {15'h0, busy}, 16'h1);
    check("err_cleared_by_sync", {15'h0, err}, 16'h0);
    send_byte(f.a);
    send_byte(f.len);
    fetch_addr = ~f.a;
    #1;
    check("addr_is_wptr_when_busy", {8'h00, addr}, {8'h00, f.a});
    n = (f.len == 8'h00) ? 256 : int'(f.len);
    for (int i = 0; i < n; i++) begin
      d = f.first + f.step * 8'(i);
      exp_q.push_back('{a: f.a + 8'(i), d: d});
      send_byte(d);
    end
    send_byte(f.chk);
    @(negedge clk);
    check("done_pulse", {15'h0, done}, {15'h0, f.exp_done});
    check("ready_low_in_done", {15'h0, in_ready}, 16'h0);
    check("busy_in_done", {15'h0, busy}, 16'h1);
    @(posedge clk);
    #1;
    check("busy_after_done", {15'h0, busy}, 16'h0);
    check("done_one_cycle", {15'h0, done}, 16'h0);
    check("err_after_frame", {15'h0, err}, {15'h0, f.exp_err});
    check("writes_drained", 16'(exp_q.size()), 16'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t tbl[4];
    tbl[0] = '{a: 8'h10, len: 8'h03, first: 8'h01, step: 8'h01, chk: 8'h06, exp_done: 1'b1, exp_err: 1'b0};
    tbl[1] = '{a: 8'hFE, len: 8'h03, first: 8'h11, step: 8'h11, chk: 8'h66, exp_done: 1'b1, exp_err: 1'b0};
    tbl[2] = '{a: 8'h00, len: 8'h00, first: 8'h00, step: 8'h01, chk: 8'h80, exp_done: 1'b1, exp_err: 1'b0};
    tbl[3] = '{a: 8'h20, len: 8'h02, first: 8'h05, step: 8'h00, chk: 8'h00, exp_done: 1'b0, exp_err: 1'b1};

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    fetch_addr = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_write", {15'h0, write}, 16'h0);
    check("rst_writeop", {8'h00, writeop}, 16'h0);
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_done", {15'h0, done}, 16'h0);
    check("rst_err", {15'h0, err}, 16'h0);
    check("rst_in_ready", {15'h0, in_ready}, 16'h1);
    check("rst_addr", {8'h00, addr}, 16'h003C);
    fetch_addr = 8'hC3;
    #1;
    check("addr_tracks_fetch", {8'h00, addr}, 16'h00C3);

    // Stray bytes while idle are swallowed without any write.
    send_byte(8'h00);
    send_byte(8'h5A);
    @(negedge clk);
    check("stray_busy", {15'h0, busy}, 16'h0);
    check("stray_err", {15'h0, err}, 16'h0);
    check("stray_ready", {15'h0, in_ready}, 16'h1);
    @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) send_frame(tbl[t]);

    // A new SYNC clears the error, then the frame stalls mid-data until it times out.
    send_byte(8'hA5);
    check("sync_clears_err", {15'h0, err}, 16'h0);
    send_byte(8'h40);
    send_byte(8'h04);
    exp_q.push_back('{a: 8'h40, d: 8'hAA});
    send_byte(8'hAA);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("tmo_not_yet_busy", {15'h0, busy}, 16'h1);
    check("tmo_not_yet_err", {15'h0, err}, 16'h0);
    @(posedge clk);
    #1;
    check("tmo_busy", {15'h0, busy}, 16'h0);
    check("tmo_err", {15'h0, err}, 16'h1);
    check("tmo_ready", {15'h0, in_ready}, 16'h1);
    check("tmo_write_kept", 16'(exp_q.size()), 16'h0);
    fetch_addr = 8'h77;
    #1;
    check("tmo_addr_fetch", {8'h00, addr}, 16'h0077);

    // Reset in the middle of the data phase.
    send_byte(8'hA5);
    send_byte(8'h30);
    send_byte(8'h04);
    exp_q.push_back('{a: 8'h30, d: 8'h9A});
    send_byte(8'h9A);
    exp_q.push_back('{a: 8'h31, d: 8'h9B});
    send_byte(8'h9B);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_write", {15'h0, write}, 16'h0);
    check("midrst_busy", {15'h0, busy}, 16'h0);
    check("midrst_err", {15'h0, err}, 16'h0);
    check("midrst_writes_seen", 16'(exp_q.size()), 16'h0);
    check("midrst_addr_fetch", {8'h00, addr}, 16'h0077);

    send_frame('{a: 8'h30, len: 8'h01, first: 8'h77, step: 8'h00, chk: 8'h77, exp_done: 1'b1, exp_err: 1'b0});

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
